// File: rtl/if_prefetch.sv
// Instruction-fetch prefetcher: issues word fetches over req/gnt/rvalid, buffers
// returned words with their PCs and hands them to ID; redirects flush and discard.
module if_prefetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_S = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0]   BOOT_PC = {BOOT_ADDR[31:2], 2'b00};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [31:0]                 fetch_pc_q, resp_pc_q, pend_pc_q;
  logic                        pend_q;
  logic [CW-1:0]               outst_q, disc_q, cnt_q, outst_d, cnt_d;
  logic [AW-1:0]               rd_ptr_q, wr_ptr_q;
  logic [FIFO_DEPTH-1:0][31:0] buf_data_q, buf_pc_q;
  logic                        gnt, push, pop, credit_now, credit_next;
  logic [31:0]                 tgt;

  assign tgt           = {branch_target_i[31:2], 2'b00};
  assign gnt           = (state_q == S_REQ) && instr_gnt_i;
  assign instr_req_o   = (state_q == S_REQ);
  assign instr_addr_o  = fetch_pc_q;
  assign instr_valid_o = (cnt_q != '0) && !branch_i;
  assign instr_rdata_o = buf_data_q[rd_ptr_q];
  assign instr_pc_o    = buf_pc_q[rd_ptr_q];
  assign pop           = instr_valid_o && instr_ready_i;
  assign push          = instr_rvalid_i && (disc_q == '0) && !branch_i &&
                         ((cnt_q != DEPTH_C) || pop);

  // Discarded in-flight words stay in outst_q, so credit covers them too.
  assign outst_d     = outst_q + CW'(gnt) - CW'(instr_rvalid_i);
  assign cnt_d       = branch_i ? '0 : (cnt_q + CW'(push) - CW'(pop));
  assign credit_now  = fetch_enable_i && (({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_S);
  assign credit_next = fetch_enable_i && (({1'b0, outst_d} + {1'b0, cnt_d}) < DEPTH_S);

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (credit_now) state_d = S_REQ;
    end else if (gnt && !credit_next) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= BOOT_PC;
      resp_pc_q  <= BOOT_PC;
      pend_pc_q  <= '0;
      pend_q     <= 1'b0;
      outst_q    <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      buf_data_q <= '0;
      buf_pc_q   <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;

      if (branch_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          buf_data_q[wr_ptr_q] <= instr_rdata_i;
          buf_pc_q[wr_ptr_q]   <= resp_pc_q;
          wr_ptr_q             <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end

      // Everything still in flight after this cycle belongs to the old path.
      if (branch_i) begin
        resp_pc_q <= tgt;
        disc_q    <= outst_d;
      end else begin
        if (push) resp_pc_q <= resp_pc_q + 32'd4;
        disc_q <= disc_q - CW'(instr_rvalid_i && (disc_q != '0)) + CW'(gnt && pend_q);
      end

      // A pending request cannot be withdrawn; the redirect waits for its grant.
      if (gnt) begin
        pend_q <= 1'b0;
        if (branch_i)    fetch_pc_q <= tgt;
        else if (pend_q) fetch_pc_q <= pend_pc_q;
        else             fetch_pc_q <= fetch_pc_q + 32'd4;
      end else if (branch_i) begin
        if (state_q == S_REQ) begin
          pend_q    <= 1'b1;
          pend_pc_q <= tgt;
        end else begin
          fetch_pc_q <= tgt;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: randomized memory/ID/branch stimulus checked against a
// queue-based model of requests, in-flight words and the instruction buffer.
module tb_if_prefetch;

  localparam logic [31:0] BOOT  = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_enable_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  if_prefetch #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fetch_enable_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o),
    .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic keep; int due; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } out_t;

  mem_t        mem_q[$];
  out_t        out_q[$];
  logic [31:0] gnt_log[$], out_log[$];
  logic [31:0] exp_addr, pend_tgt, br_tgt_force;
  logic [15:0] seq;
  logic        stale, exp_req, br_force;
  int          cyc, last_due, first_vld, n_grant;
  int          gnt_pct, lat_lo, lat_hi, rdy_pct, br_pct, en_pct;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Asserts reset mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; branch_i = 1'b0;
    #1;
    chk("rst_req",   32'(instr_req_o), 32'd0);
    chk("rst_addr",  instr_addr_o, BOOT & ~32'd3);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'd0);
    chk("rst_pc",    instr_pc_o, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mem_q.delete(); out_q.delete(); gnt_log.delete(); out_log.delete();
    exp_addr = BOOT & ~32'd3; stale = 1'b0; exp_req = 1'b0; br_force = 1'b0;
    cyc = 0; last_due = -1; first_vld = -1; n_grant = 0;
  endtask

  task automatic step();
    int   sum0, due;
    logic ev;
    mem_t m;
    out_t o;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'd0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_q[0].data;
    end
    instr_gnt_i     = instr_req_o && ($urandom_range(99) < gnt_pct);
    branch_i        = br_force || ($urandom_range(99) < br_pct);
    branch_target_i = br_force ? br_tgt_force :
                      ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
    br_force        = 1'b0;
    instr_ready_i   = ($urandom_range(99) < rdy_pct);
    fetch_enable_i  = ($urandom_range(99) < en_pct);

    @(negedge clk);
    chk("req", 32'(instr_req_o), 32'(exp_req));
    if (instr_req_o) chk("addr", instr_addr_o, exp_addr);
    ev = (out_q.size() > 0) && !branch_i;
    chk("valid", 32'(instr_valid_o), 32'(ev));
    if (ev) begin
      chk("pc", instr_pc_o, out_q[0].pc);
      chk("rdata", instr_rdata_o, out_q[0].data);
    end
    if (instr_valid_o && first_vld < 0) first_vld = cyc;

    sum0 = mem_q.size() + out_q.size();
    if (ev && instr_ready_i) begin
      out_log.push_back(out_q[0].pc);
      void'(out_q.pop_front());
    end
    if (instr_rvalid_i) begin
      m = mem_q.pop_front();
      if (m.keep && !branch_i) begin
        chk("rv_room", 32'(out_q.size() < DEPTH), 32'd1);
        o.pc = m.addr; o.data = m.data;
        out_q.push_back(o);
      end
    end
    if (instr_req_o && instr_gnt_i) begin
      seq++;
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = instr_addr_o;
      m.data = {instr_addr_o[15:0], seq} ^ 32'h5A5A_C3C3;
      m.keep = !branch_i && !stale;
      m.due  = due;
      mem_q.push_back(m);
      gnt_log.push_back(instr_addr_o);
      n_grant++;
      if (stale) begin exp_addr = pend_tgt; stale = 1'b0; end
      else exp_addr = exp_addr + 32'd4;
      chk("credit", 32'(mem_q.size() + out_q.size() <= DEPTH), 32'd1);
    end
    if (branch_i) begin
      out_q.delete();
      foreach (mem_q[i]) mem_q[i].keep = 1'b0;
      if (instr_req_o && !instr_gnt_i) begin
        stale = 1'b1; pend_tgt = branch_target_i & ~32'd3;
      end else begin
        exp_addr = branch_target_i & ~32'd3; stale = 1'b0;
      end
    end
    if (instr_req_o && !instr_gnt_i) exp_req = 1'b1;
    else if (instr_req_o) exp_req = fetch_enable_i && (mem_q.size() + out_q.size() < DEPTH);
    else exp_req = fetch_enable_i && (sum0 < DEPTH);

    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int g, input int lo, input int hi, input int r, input int b, input int e);
    gnt_pct = g; lat_lo = lo; lat_hi = hi; rdy_pct = r; br_pct = b; en_pct = e;
  endtask

  initial begin
    fetch_enable_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    branch_i = 1'b0; branch_target_i = '0; instr_ready_i = 1'b0; seq = '0;
    cfg(100, 1, 1, 100, 0, 100);
    #2;
    do_reset();

    // Boot: immediate gnt, 1-cycle rvalid, ID always ready.
    for (int i = 0; i < 12; i++) step();
    chk("first_vld_cyc", 32'(first_vld), 32'd3);
    chk("boot_grants", 32'(gnt_log.size() >= 3), 32'd1);
    if (gnt_log.size() >= 3) begin
      chk("boot_a0", gnt_log[0], 32'h100);
      chk("boot_a1", gnt_log[1], 32'h104);
      chk("boot_a2", gnt_log[2], 32'h108);
    end
    chk("boot_outs", 32'(out_log.size() >= 2), 32'd1);
    if (out_log.size() >= 2) begin
      chk("boot_o0", out_log[0], 32'h100);
      chk("boot_o1", out_log[1], 32'h104);
    end

    // ID stalled: credit caps grants at the buffer depth.
    do_reset();
    cfg(100, 1, 1, 0, 0, 100);
    for (int i = 0; i < 10; i++) step();
    chk("stall_grants", 32'(n_grant), 32'(DEPTH));
    chk("stall_req", 32'(instr_req_o), 32'd0);
    rdy_pct = 100;
    for (int i = 0; i < 8; i++) step();
    chk("stall_resume", 32'(n_grant > DEPTH), 32'd1);

    // Redirect with two words in flight.
    do_reset();
    cfg(100, 6, 6, 0, 0, 100);
    for (int i = 0; i < 10 && mem_q.size() < 2; i++) step();
    chk("br_inflight", 32'(mem_q.size()), 32'd2);
    cfg(100, 1, 1, 100, 0, 100);
    br_force = 1'b1; br_tgt_force = 32'h203;
    gnt_log.delete(); out_log.delete();
    step();
    for (int i = 0; i < 20; i++) step();
    chk("br_gnt", 32'(gnt_log.size() > 0), 32'd1);
    if (gnt_log.size() > 0) chk("br_a0", gnt_log[0], 32'h200);
    chk("br_out", 32'(out_log.size() > 0), 32'd1);
    if (out_log.size() > 0) chk("br_o0", out_log[0], 32'h200);

    // Redirect while a request waits for grant.
    do_reset();
    cfg(0, 1, 1, 100, 0, 100);
    for (int i = 0; i < 5; i++) step();
    chk("hold_req", 32'(instr_req_o), 32'd1);
    br_force = 1'b1; br_tgt_force = 32'h203;
    step();
    gnt_pct = 100;
    for (int i = 0; i < 12; i++) step();
    chk("hold_gnts", 32'(gnt_log.size() >= 2), 32'd1);
    if (gnt_log.size() >= 2) begin
      chk("hold_a0", gnt_log[0], 32'h100);
      chk("hold_a1", gnt_log[1], 32'h200);
    end
    if (out_log.size() > 0) chk("hold_o0", out_log[0], 32'h200);
    else chk("hold_out", 32'd0, 32'd1);

    // Fetch PC wraps past the top of the address space.
    do_reset();
    cfg(100, 1, 1, 100, 0, 100);
    step();
    br_force = 1'b1; br_tgt_force = 32'hFFFF_FFFC;
    step();
    gnt_log.delete(); out_log.delete();
    for (int i = 0; i < 12; i++) step();
    if (gnt_log.size() >= 2 && out_log.size() >= 2) begin
      chk("wrap_a0", gnt_log[0], 32'hFFFF_FFFC);
      chk("wrap_a1", gnt_log[1], 32'h0);
      chk("wrap_o0", out_log[0], 32'hFFFF_FFFC);
      chk("wrap_o1", out_log[1], 32'h0);
    end else chk("wrap_cnt", 32'd0, 32'd1);

    // Reset with two words outstanding; restart from the boot address.
    do_reset();
    cfg(100, 4, 4, 0, 0, 100);
    for (int i = 0; i < 3; i++) step();
    chk("mid_inflight", 32'(mem_q.size()), 32'd2);
    do_reset();
    cfg(100, 1, 1, 100, 0, 100);
    for (int i = 0; i < 4; i++) step();
    if (gnt_log.size() > 0) chk("mid_a0", gnt_log[0], 32'h100);
    else chk("mid_gnt", 32'd0, 32'd1);

    // Randomized traffic with periodic traffic-mix changes and occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0)
        cfg($urandom_range(100, 30), 1, $urandom_range(5, 1), $urandom_range(100, 20),
            $urandom_range(15, 0), $urandom_range(100, 50));
      if (i % 1000 == 999) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
